load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: sequences core loads/stores onto a byte-addressed memory port.
// Define MISALIGN_SPLIT_EN to split misaligned accesses into byte beats.
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_we,
  output logic [1:0]  mem_func_in,
  output logic [2:0]  mem_func_out,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [1:0]  FN_SB = 2'd0;
  localparam logic [1:0]  FN_SH = 2'd1;
  localparam logic [1:0]  FN_SW = 2'd2;
  localparam logic [2:0]  FN_LW = 3'd2;
  localparam logic [2:0]  FN_LBU = 3'd4;
  localparam logic [32:0] LAST_ADDR = 33'd1023;

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  state_t      state;
  state_t      state_nx;

  logic        accept;
  logic [1:0]  bytes_m1;
  logic        mis;
  logic        mis_err;
  logic        split_in;
  logic        bmode_in;
  logic        err_in;
  logic [32:0] end_addr;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic        r_bmode;
  logic [1:0]  r_last;
  logic [1:0]  beat;
  logic [31:0] asm_q;
  logic [7:0]  wbyte;
  logic        sx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Request byte count minus one, used for range check and beat count
  always_comb begin
    bytes_m1 = 2'd0;
    unique case (1'b1)
      req_size == 2'd1: bytes_m1 = 2'd1;
      req_size == 2'd2: bytes_m1 = 2'd3;
      default:          bytes_m1 = 2'd0;
    endcase
  end

  assign mis = (req_size == 2'd1 && req_addr[0])
            || (req_size == 2'd2 && req_addr[1:0] != 2'd0);

`ifdef MISALIGN_SPLIT_EN
  assign split_in = mis;
  assign mis_err  = 1'b0;
`else
  assign split_in = 1'b0;
  assign mis_err  = mis;
`endif

  assign end_addr = {1'b0, req_addr} + {31'd0, bytes_m1};
  assign err_in   = (req_size == 2'd3) || (end_addr > LAST_ADDR) || mis_err;
  assign bmode_in = (req_size == 2'd0)
                 || (req_size == 2'd1 && !req_write)
                 || split_in;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: errors skip straight to the response cycle
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = err_in ? RESP : BEAT;
      BEAT:    if (beat == r_last) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, beat counter and load assembly register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_bmode <= 1'b0;
      r_last  <= 2'd0;
      beat    <= 2'd0;
      asm_q   <= '0;
    end else if (accept) begin
      r_write <= req_write;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_err   <= err_in;
      r_bmode <= bmode_in;
      r_last  <= bmode_in ? bytes_m1 : 2'd0;
      beat    <= 2'd0;
      asm_q   <= '0;
    end else if (state == BEAT) begin
      if (!r_write) begin
        if (r_bmode) asm_q[{beat, 3'b000} +: 8] <= mem_data_out[7:0];
        else         asm_q <= mem_data_out;
      end
      beat <= beat + 2'd1;
    end
  end

  assign wbyte = r_wdata[{beat, 3'b000} +: 8];

  // Memory port: idle outside BEAT
  always_comb begin
    mem_we       = 1'b0;
    mem_func_in  = FN_SB;
    mem_func_out = FN_LBU;
    mem_address  = '0;
    mem_data_in  = '0;
    if (state == BEAT) begin
      mem_we = r_write;
      if (r_bmode) begin
        mem_address = r_addr + {30'd0, beat};
        if (r_write) mem_data_in = {24'd0, wbyte};
      end else begin
        mem_address = r_addr;
        if (r_write) begin
          mem_data_in = r_wdata;
          mem_func_in = (r_size == 2'd1) ? FN_SH : FN_SW;
        end else begin
          mem_func_out = FN_LW;
        end
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_error = (state == RESP) && r_err;
  assign sx        = !r_uns;

  // Response data: extend loads, zero for stores and errors
  always_comb begin
    rsp_rdata = '0;
    if (state == RESP && !r_err && !r_write) begin
      unique case (1'b1)
        r_size == 2'd0: rsp_rdata = {{24{sx && asm_q[7]}}, asm_q[7:0]};
        r_size == 2'd1: rsp_rdata = {{16{sx && asm_q[15]}}, asm_q[15:0]};
        default:        rsp_rdata = asm_q;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a byte-array reference model.
// Expectations follow MISALIGN_SPLIT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam logic [1:0] F_SB = 2'd0;
  localparam logic [1:0] F_SH = 2'd1;
  localparam logic [1:0] F_SW = 2'd2;
  localparam logic [2:0] F_LW = 3'd2;
  localparam logic [2:0] F_LBU = 3'd4;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  fin;
    logic        lw;
    logic [31:0] din;
    logic [31:0] mask;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_we;
  logic [1:0]  mem_func_in;
  logic [2:0]  mem_func_out;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_we(mem_we), .mem_func_in(mem_func_in),
    .mem_func_out(mem_func_out), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  logic [7:0] mem [1024];
  logic [7:0] ref_mem [1024];
  logic [7:0] snap [1024];
  wire  [9:0] ix = mem_address[9:0];

  assign mem_data_out = (mem_func_out == F_LW)
    ? {mem[ix + 10'd3], mem[ix + 10'd2], mem[ix + 10'd1], mem[ix]}
    : {24'd0, mem[ix]};

  always @(posedge clock) begin
    if (mem_we) begin
      mem[ix] = mem_data_in[7:0];
      if (mem_func_in != F_SB) mem[ix + 10'd1] = mem_data_in[15:8];
      if (mem_func_in == F_SW) begin
        mem[ix + 10'd2] = mem_data_in[23:16];
        mem[ix + 10'd3] = mem_data_in[31:24];
      end
    end
  end

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  exp_t        sb[$];
  beat_t       bq[$];
  logic [31:0] last_rdata;
  logic        last_err;
  exp_t        me;
  beat_t       mb;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: responses, memory beats and idle port
  always @(negedge clock) begin
    if (reset) begin
      if (rsp_valid) begin
        last_rdata = rsp_rdata;
        last_err   = rsp_error;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with none pending");
        end else begin
          me = sb.pop_front();
          chk("rsp_error", 32'(rsp_error), 32'(me.err));
          if (!me.err) chk("rsp_rdata", rsp_rdata, me.rdata);
          chk("latency", 32'(cyc + 1 - me.acc), 32'(me.lat));
          chk("beats_left", 32'(bq.size()), 32'd0);
          chk("rsp_mem_we", 32'(mem_we), 32'd0);
        end
      end else if (!req_ready) begin
        if (bq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: addr=%h we=%b", mem_address, mem_we);
        end else begin
          mb = bq.pop_front();
          chk("beat_addr", mem_address, mb.addr);
          chk("beat_we", 32'(mem_we), 32'(mb.we));
          chk("beat_fout", 32'(mem_func_out), mb.lw ? 32'(F_LW) : 32'(F_LBU));
          if (mb.we) begin
            chk("beat_fin", 32'(mem_func_in), 32'(mb.fin));
            chk("beat_din", mem_data_in & mb.mask, mb.din & mb.mask);
          end
        end
      end else begin
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_fout", 32'(mem_func_out), 32'(F_LBU));
        chk("idle_addr", mem_address, 32'd0);
        chk("idle_din", mem_data_in, 32'd0);
      end
    end
  end

  // Reference model plus driver for one request
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int     n;
    int     nb;
    int     idx;
    bit     mis;
    bit     err;
    longint v;
    longint m;
    exp_t   e;
    beat_t  b;
    beat_t  bl[$];
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL ready_timeout: req_ready=0 want 1 after %0d cycles", n);
      return;
    end
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = (sz != 2'd3) && ((int'(a[1:0]) % nb) != 0);
    err = (sz == 2'd3) || (longint'(a) + longint'(nb) - 1 > 1023)
       || (mis && !SPLIT);
    idx = int'(a[9:0]);
    e.rdata = '0;
    e.err   = err;
    e.lat   = 1;
    if (!err) begin
      if (wr && !mis && sz != 2'd0) begin
        b.addr = a;
        b.we   = 1'b1;
        b.fin  = (sz == 2'd1) ? F_SH : F_SW;
        b.lw   = 1'b0;
        b.din  = wd;
        b.mask = (sz == 2'd1) ? 32'h0000FFFF : 32'hFFFFFFFF;
        bl.push_back(b);
      end else if (!wr && !mis && sz == 2'd2) begin
        b.addr = a;
        b.we   = 1'b0;
        b.fin  = F_SB;
        b.lw   = 1'b1;
        b.din  = '0;
        b.mask = '0;
        bl.push_back(b);
      end else begin
        for (int k = 0; k < nb; k++) begin
          b.addr = a + 32'(k);
          b.we   = wr;
          b.fin  = F_SB;
          b.lw   = 1'b0;
          b.din  = {24'd0, wd[8*k +: 8]};
          b.mask = 32'h000000FF;
          bl.push_back(b);
        end
      end
      if (wr) begin
        for (int k = 0; k < nb; k++) ref_mem[idx + k] = wd[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < nb; k++) v = v | (longint'(ref_mem[idx + k]) << (8 * k));
        m = (longint'(1) << (8 * nb)) - 1;
        if (!uns && v[8*nb-1]) v = v | ~m;
        e.rdata = v[31:0];
      end
      e.lat = bl.size() + 1;
    end
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clock);
    #1;
    e.acc = cyc;
    sb.push_back(e);
    foreach (bl[i]) bq.push_back(bl[i]);
    req_valid    = 1'b0;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ab_wr;
    logic [1:0]  ab_sz;
    logic [31:0] ab_a;
    logic [31:0] ab_wd;
    logic [1:0]  s;
    logic [31:0] ra;
    int          r;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_error", 32'(rsp_error), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_fout", 32'(mem_func_out), 32'(F_LBU));
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_din", mem_data_in, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_done();
    chk("lw_0x10", last_rdata, 32'hDEADBEEF);

    issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h34);
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h92);
    issue(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
    wait_done();
    chk("lh_0x20", last_rdata, 32'hFFFF9234);
    issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    wait_done();
    chk("lhu_0x20", last_rdata, 32'h00009234);

    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hA1B2C3D4);
    issue(1'b0, 2'd2, 1'b0, 32'h41, 32'h0);
    wait_done();
`ifdef MISALIGN_SPLIT_EN
    chk("lw_0x41_split", last_rdata, 32'h00A1B2C3);
`else
    chk("lw_0x41_err", 32'(last_err), 32'd1);
`endif

    issue(1'b1, 2'd0, 1'b0, 32'h400, 32'h55);
    wait_done();
    chk("sb_0x400_err", 32'(last_err), 32'd1);
    issue(1'b0, 2'd3, 1'b0, 32'h8, 32'h0);
    wait_done();
    chk("size3_err", 32'(last_err), 32'd1);
    issue(1'b1, 2'd2, 1'b0, 32'h3FC, 32'h11223344);
    issue(1'b0, 2'd0, 1'b0, 32'h3FF, 32'h0);
    wait_done();
    chk("lb_0x3ff", last_rdata, 32'h00000011);
    issue(1'b0, 2'd1, 1'b0, 32'h3FF, 32'h0);
    wait_done();
    chk("lh_0x3ff_err", 32'(last_err), 32'd1);

`ifdef MISALIGN_SPLIT_EN
    ab_wr = 1'b1;
    ab_sz = 2'd2;
    ab_a  = 32'h81;
    ab_wd = 32'hCAFEF00D;
`else
    ab_wr = 1'b0;
    ab_sz = 2'd1;
    ab_a  = 32'h20;
    ab_wd = 32'h0;
`endif
    snap = ref_mem;
    issue(ab_wr, ab_sz, 1'b0, ab_a, ab_wd);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    sb.delete();
    bq.delete();
    ref_mem = snap;
    if (ab_wr) ref_mem[int'(ab_a[9:0])] = ab_wd[7:0];
    @(negedge clock);
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h81, 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h81, 32'h0);
    wait_done();

    for (int t = 0; t < 300; t++) begin
      r = int'($urandom_range(0, 9));
      s = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 7) == 0) ra = 32'($urandom_range(1016, 1030));
      else                           ra = 32'($urandom_range(0, 1023));
      issue(1'($urandom), s, 1'($urandom), ra, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
    end
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
